// File: rtl/mux_scan_nch_if.sv
// Bus bundle for mux_scan_nch: channel words and controls in, selected word/enable/index out.
// The selector drives through the slave modport; the host side uses master.
interface mux_scan_nch_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] DIN;
  logic                      MODE;
  logic [SELW-1:0]           SEL_MAN;
  logic                      HOLD;
  logic [WIDTH-1:0]          OUT;
  logic [CHANNELS-1:0]       EN_OH;
  logic [SELW-1:0]           IDX;
  logic                      TICK;

  modport master (
    output DIN, MODE, SEL_MAN, HOLD,
    input  OUT, EN_OH, IDX, TICK
  );

  modport slave (
    input  DIN, MODE, SEL_MAN, HOLD,
    output OUT, EN_OH, IDX, TICK
  );
endinterface

// File: rtl/mux_scan_nch.sv
// N-channel time-multiplexing selector: auto scan on a prescaled tick or manual pick,
// registered word output plus one-hot enable with dead-time blanking on channel changes.
module mux_scan_nch #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DIV      = 50000,
  parameter int BLANK    = 2
) (
  input  logic               CLK,
  input  logic               RST,
  mux_scan_nch_if.slave      bus
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNTW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW   = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

  localparam logic [CNTW-1:0] CNT_LAST   = CNTW'(DIV - 1);
  localparam logic [SELW-1:0] IDX_LAST   = SELW'(CHANNELS - 1);
  localparam logic [BW-1:0]   BLANK_LOAD = BW'(BLANK);

  logic [CNTW-1:0]     r_cnt;
  logic [SELW-1:0]     r_idx;
  logic [BW-1:0]       r_bcnt;
  logic [WIDTH-1:0]    r_out;
  logic [CHANNELS-1:0] r_en_oh;
  logic                r_tick;

  logic [CNTW-1:0]     w_cnt_next;
  logic [SELW-1:0]     w_idx_next;
  logic [BW-1:0]       w_bcnt_next;
  logic                w_tick_next;
  logic                w_blank_load;
  logic [WIDTH-1:0]    w_words [CHANNELS];
  logic [WIDTH-1:0]    w_word;
  logic [CHANNELS-1:0] w_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign w_words[gi]  = bus.DIN[gi*WIDTH +: WIDTH];
      assign w_onehot[gi] = (r_idx == SELW'(gi));
    end
  endgenerate

  // Explicit compare-mux keeps out-of-range index codes harmless for non-power-of-two CHANNELS.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_idx == SELW'(i)) begin
        w_word = w_words[i];
      end
    end
  end

  always_comb begin
    w_cnt_next  = r_cnt;
    w_idx_next  = r_idx;
    w_tick_next = 1'b0;
    if (!bus.HOLD) begin
      if (!bus.MODE) begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_next  = '0;
          w_idx_next  = (r_idx == IDX_LAST) ? '0 : r_idx + SELW'(1);
          w_tick_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNTW'(1);
        end
      end else begin
        w_cnt_next = '0;
        w_idx_next = (bus.SEL_MAN > IDX_LAST) ? IDX_LAST : bus.SEL_MAN;
      end
    end
  end

  // Blanking starts on the same edge the index moves, so the old channel never shows the new word.
  assign w_blank_load = (BLANK != 0) && (w_idx_next != r_idx);

  always_comb begin
    w_bcnt_next = r_bcnt;
    if (w_blank_load) begin
      w_bcnt_next = BLANK_LOAD;
    end else if (r_bcnt != '0) begin
      w_bcnt_next = r_bcnt - BW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_bcnt  <= '0;
      r_out   <= '0;
      r_en_oh <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_bcnt  <= w_bcnt_next;
      r_out   <= w_word;
      r_en_oh <= ((r_bcnt != '0) || w_blank_load) ? '0 : w_onehot;
      r_tick  <= w_tick_next;
    end
  end

  assign bus.OUT   = r_out;
  assign bus.EN_OH = r_en_oh;
  assign bus.IDX   = r_idx;
  assign bus.TICK  = r_tick;
endmodule

// File: tb/tb_mux_scan_nch.sv
// Cycle-by-cycle vector bench for mux_scan_nch (WIDTH=4, CHANNELS=3, DIV=4, BLANK=1).
module tb_mux_scan_nch;
  localparam logic [11:0] D0 = 12'hCBA;
  localparam logic [11:0] D1 = 12'hC7A;

  typedef struct {
    logic        rst;
    logic        mode;
    logic        hold;
    logic [1:0]  sel;
    logic [11:0] din;
    logic [3:0]  out;
    logic [2:0]  en;
    logic [1:0]  idx;
    logic        tick;
  } vec_t;

  typedef struct {
    int         step;
    logic [3:0] out;
    logic [2:0] en;
    logic [1:0] idx;
    logic       tick;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  vec_t vecs[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mux_scan_nch_if #(.WIDTH(4), .CHANNELS(3)) bus ();

  mux_scan_nch #(.WIDTH(4), .CHANNELS(3), .DIV(4), .BLANK(1)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  task automatic add(input logic r, input logic m, input logic h, input logic [1:0] s,
                     input logic [11:0] d, input logic [3:0] o, input logic [2:0] e,
                     input logic [1:0] i, input logic t);
    vec_t v;
    v.rst = r; v.mode = m; v.hold = h; v.sel = s; v.din = d;
    v.out = o; v.en = e; v.idx = i; v.tick = t;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int step, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL step%0d %s got=%h want=%h", step, name, got, want);
    end
  endtask

  initial begin
    exp_t e;
    int   n;
    int   t1;
    int   t2;
    bus.DIN = D0; bus.MODE = 1'b0; bus.SEL_MAN = 2'd0; bus.HOLD = 1'b0;

    // reset, then auto scan 0,1,2,0 with one blank cycle on each change
    add(1,0,0,0,D0, 4'h0,3'b000,2'd0,0);
    add(1,0,0,0,D0, 4'h0,3'b000,2'd0,0);
    add(0,0,0,0,D0, 4'hA,3'b001,2'd0,0);
    add(0,0,0,0,D0, 4'hA,3'b001,2'd0,0);
    add(0,0,0,0,D0, 4'hA,3'b001,2'd0,0);
    add(0,0,0,0,D0, 4'hA,3'b000,2'd1,1);
    add(0,0,0,0,D0, 4'hB,3'b000,2'd1,0);
    add(0,0,0,0,D0, 4'hB,3'b010,2'd1,0);
    add(0,0,0,0,D0, 4'hB,3'b010,2'd1,0);
    add(0,0,0,0,D0, 4'hB,3'b000,2'd2,1);
    add(0,0,0,0,D0, 4'hC,3'b000,2'd2,0);
    add(0,0,0,0,D0, 4'hC,3'b100,2'd2,0);
    add(0,0,0,0,D0, 4'hC,3'b100,2'd2,0);
    add(0,0,0,0,D0, 4'hC,3'b000,2'd0,1);
    add(0,0,0,0,D0, 4'hA,3'b000,2'd0,0);
    add(0,0,0,0,D0, 4'hA,3'b001,2'd0,0);
    // hold at cnt=2 for five cycles, then two more cycles to the advance
    for (int k = 0; k < 5; k++) add(0,0,1,0,D0, 4'hA,3'b001,2'd0,0);
    add(0,0,0,0,D0, 4'hA,3'b001,2'd0,0);
    add(0,0,0,0,D0, 4'hA,3'b000,2'd1,1);
    // manual: clamp 3->2, steady select, same value, then move to 1
    add(0,1,0,3,D0, 4'hB,3'b000,2'd2,0);
    add(0,1,0,3,D0, 4'hC,3'b000,2'd2,0);
    add(0,1,0,3,D0, 4'hC,3'b100,2'd2,0);
    add(0,1,0,3,D0, 4'hC,3'b100,2'd2,0);
    add(0,1,0,2,D0, 4'hC,3'b100,2'd2,0);
    add(0,1,0,1,D0, 4'hC,3'b000,2'd1,0);
    // back to auto from idx 1: advance on the fourth edge
    add(0,0,0,0,D0, 4'hB,3'b000,2'd1,0);
    add(0,0,0,0,D0, 4'hB,3'b010,2'd1,0);
    add(0,0,0,0,D0, 4'hB,3'b010,2'd1,0);
    add(0,0,0,0,D0, 4'hB,3'b000,2'd2,1);
    add(0,0,0,0,D0, 4'hC,3'b000,2'd2,0);
    // reset in the middle of a blank
    add(1,0,0,0,D0, 4'h0,3'b000,2'd0,0);
    add(0,0,0,0,D0, 4'hA,3'b001,2'd0,0);
    add(0,0,0,0,D0, 4'hA,3'b001,2'd0,0);
    add(0,0,0,0,D0, 4'hA,3'b001,2'd0,0);
    // hold over an edge where the advance is due: deferred, not lost
    add(0,0,1,0,D0, 4'hA,3'b001,2'd0,0);
    add(0,0,1,0,D0, 4'hA,3'b001,2'd0,0);
    add(0,0,0,0,D0, 4'hA,3'b000,2'd1,1);
    // DIN change on the displayed channel passes straight through
    add(0,0,0,0,D1, 4'h7,3'b000,2'd1,0);
    add(0,0,0,0,D1, 4'h7,3'b010,2'd1,0);

    for (int s = 0; s < vecs.size(); s++) begin
      rst = vecs[s].rst;
      bus.MODE = vecs[s].mode;
      bus.HOLD = vecs[s].hold;
      bus.SEL_MAN = vecs[s].sel;
      bus.DIN = vecs[s].din;
      e.step = s; e.out = vecs[s].out; e.en = vecs[s].en; e.idx = vecs[s].idx; e.tick = vecs[s].tick;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("out",  e.step, bus.OUT,          e.out);
      check("en",   e.step, {1'b0, bus.EN_OH}, {1'b0, e.en});
      check("idx",  e.step, {2'b0, bus.IDX},   {2'b0, e.idx});
      check("tick", e.step, {3'b0, bus.TICK},  {3'b0, e.tick});
      $display("step %0d rst=%0b mode=%0b hold=%0b sel=%0d -> out=%h en=%b idx=%0d tick=%0b",
               s, vecs[s].rst, vecs[s].mode, vecs[s].hold, vecs[s].sel,
               bus.OUT, bus.EN_OH, bus.IDX, bus.TICK);
    end

    // free-running auto scan: distance between successive ticks is DIV
    t1 = -1; t2 = -1; n = 0;
    while (t2 < 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.TICK) begin
        if (t1 < 0) t1 = n;
        else t2 = n;
      end
    end
    checks++;
    if (t2 < 0) begin
      failures++;
      $display("FAIL tick_period no two ticks within 20 cycles (first=%0d)", t1);
    end else begin
      $display("tick period measured %0d cycles", t2 - t1);
      check("tick_period", 99, 4'(t2 - t1), 4'd4);
      check("idx_after", 99, {2'b0, bus.IDX}, 4'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
